// File: rtl/dadda_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dadda_pkg : Dadda height sequence, stage planning and HA/FA cells     |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
package dadda_pkg;

    localparam int MAX_COLS = 64;
    localparam int INFO_H   = 0;
    localparam int INFO_NFA = 1;
    localparam int INFO_NHA = 2;

    typedef logic [MAX_COLS-1:0][7:0] info_vec_t;

    function automatic int dadda_height(input int k);
        case (k)
            0:       return 2;
            1:       return 3;
            2:       return 4;
            3:       return 6;
            4:       return 9;
            5:       return 13;
            6:       return 19;
            7:       return 28;
            default: return 42;
        endcase
    endfunction

    function automatic int dadda_stages(input int w);
        int n;
        n = 0;
        for (int k = 0; k < 8; k++) begin
            if (dadda_height(k) < w) n++;
        end
        return n;
    endfunction

    function automatic int prod_w(input int w);
        return 2 * w;
    endfunction

    // Per-column plan of reduction stage s: input height, FA count or HA count.
    function automatic info_vec_t red_vec(input int w, input int s, input int sel);
        int        h [MAX_COLS];
        int        nst, d, cin, ex, nf, nh, v;
        info_vec_t res;
        res = '0;
        nst = dadda_stages(w);
        for (int col = 0; col < MAX_COLS; col++) begin
            h[col] = (col < 2*w-1) ? ((col < w) ? col + 1 : 2*w - 1 - col) : 0;
        end
        for (int st = 0; st <= s; st++) begin
            cin = 0;
            d   = dadda_height(nst - 1 - st);
            for (int col = 0; col < 2*w; col++) begin
                ex = h[col] + cin - d;
                nf = (ex > 0) ? ex / 2 : 0;
                nh = (ex > 0) ? ex % 2 : 0;
                if (st == s) begin
                    v = (sel == INFO_H) ? h[col] : (sel == INFO_NFA) ? nf : nh;
                    res[col] = 8'(v);
                end
                h[col] = h[col] + cin - 2*nf - nh;
                cin    = nf + nh;
            end
        end
        return res;
    endfunction

    function automatic logic [1:0] ha(input logic x, input logic y);
        return {x & y, x ^ y};
    endfunction

    function automatic logic [1:0] fa(input logic x, input logic y, input logic z);
        return {(x & y) | (z & (x ^ y)), x ^ y ^ z};
    endfunction

endpackage
`default_nettype wire

// File: rtl/dadda_reduce.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dadda_reduce : combinational Dadda tree, WIDTH x WIDTH matrix to 2 rows|
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module dadda_reduce
    import dadda_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]   pp [WIDTH],
    output logic [2*WIDTH-1:0] row_a,
    output logic [2*WIDTH-1:0] row_b
);

    localparam int PROD_W = prod_w(WIDTH);
    localparam int NST    = dadda_stages(WIDTH);

    logic [WIDTH-1:0] col0 [PROD_W];

    // pp[j][i] = a[i] & b[j] lands in column i+j.
    always_comb begin
        int cnt [PROD_W];
        for (int c = 0; c < PROD_W; c++) begin
            col0[c] = '0;
            cnt[c]  = 0;
        end
        for (int j = 0; j < WIDTH; j++) begin
            for (int i = 0; i < WIDTH; i++) begin
                col0[i+j][cnt[i+j]] = pp[j][i];
                cnt[i+j]++;
            end
        end
    end

    for (genvar s = 0; s < NST; s++) begin : g_stage
        localparam info_vec_t H_V  = red_vec(WIDTH, s, INFO_H);
        localparam info_vec_t NF_V = red_vec(WIDTH, s, INFO_NFA);
        localparam info_vec_t NH_V = red_vec(WIDTH, s, INFO_NHA);

        logic [WIDTH-1:0] src [PROD_W];
        logic [WIDTH-1:0] dst [PROD_W];

        if (s == 0) begin : g_first
            assign src = col0;
        end else begin : g_next
            assign src = g_stage[s-1].dst;
        end

        // Rows 0..cin-1 of each output column are reserved for carries from below.
        always_comb begin
            int         h, nf, nh, k, o;
            logic [1:0] r;
            h = 0; nf = 0; nh = 0; k = 0; o = 0;
            r = '0;
            for (int c = 0; c < PROD_W; c++) dst[c] = '0;
            for (int c = 0; c < PROD_W; c++) begin
                h  = int'(H_V[c]);
                nf = int'(NF_V[c]);
                nh = int'(NH_V[c]);
                k  = 0;
                o  = (c > 0) ? int'(NF_V[c-1]) + int'(NH_V[c-1]) : 0;
                for (int f = 0; f < WIDTH; f++) begin
                    if (f < nf) begin
                        r = fa(src[c][k], src[c][k+1], src[c][k+2]);
                        dst[c][o] = r[0];
                        if (c + 1 < PROD_W) dst[c+1][f] = r[1];
                        k += 3;
                        o++;
                    end
                end
                if (nh > 0) begin
                    r = ha(src[c][k], src[c][k+1]);
                    dst[c][o] = r[0];
                    if (c + 1 < PROD_W) dst[c+1][nf] = r[1];
                    k += 2;
                    o++;
                end
                for (int p = 0; p < WIDTH; p++) begin
                    if (p >= k && p < h) begin
                        dst[c][o] = src[c][p];
                        o++;
                    end
                end
            end
        end
    end

    always_comb begin
        row_a = '0;
        row_b = '0;
        for (int c = 0; c < PROD_W; c++) begin
            for (int r = 0; r < WIDTH; r++) begin
                if (r == 0) row_a[c] = g_stage[NST-1].dst[c][r];
                if (r == 1) row_b[c] = g_stage[NST-1].dst[c][r];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dadda_mul_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dadda_mul_pipe : 3-stage unsigned Dadda multiplier, valid/ready, approx|
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module dadda_mul_pipe
    import dadda_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int APPROX_COLS = 4,
    parameter int TAG_W       = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_approx,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_prod,
    output logic               out_approx,
    output logic [TAG_W-1:0]   out_tag,
    output logic               overflow
);

    localparam int PROD_W = prod_w(WIDTH);

    logic              v1, v2, v3;
    logic              load1, load2, load3;
    logic [WIDTH-1:0]  pp_d [WIDTH];
    logic [WIDTH-1:0]  pp1  [WIDTH];
    logic              approx1, approx2, approx3;
    logic [TAG_W-1:0]  tag1, tag2, tag3;
    logic [PROD_W-1:0] row_a, row_b, row_a2, row_b2, sum, prod3;

    assign load3    = !v3 || out_ready;
    assign load2    = !v2 || load3;
    assign load1    = !v1 || load2;
    assign in_ready = load1;

    always_comb begin
        pp_d = '{default: '0};
        for (int j = 0; j < WIDTH; j++) begin
            for (int i = 0; i < WIDTH; i++) begin
                pp_d[j][i] = in_a[i] & in_b[j] & ~(in_approx && (i + j < APPROX_COLS));
            end
        end
    end

    dadda_reduce #(.WIDTH(WIDTH)) u_reduce (
        .pp    (pp1),
        .row_a (row_a),
        .row_b (row_b)
    );

    // 4-bit lookahead groups: group carry-out from group generate/propagate.
    always_comb begin
        logic [PROD_W-1:0] g, p;
        logic              c, cg, gg, gp;
        g   = row_a2 & row_b2;
        p   = row_a2 ^ row_b2;
        sum = '0;
        c   = 1'b0;
        cg  = 1'b0;
        gg  = 1'b0;
        gp  = 1'b1;
        for (int base = 0; base < PROD_W; base += 4) begin
            cg = c;
            gg = 1'b0;
            gp = 1'b1;
            for (int i = 0; i < 4; i++) begin
                if (base + i < PROD_W) begin
                    sum[base+i] = p[base+i] ^ cg;
                    cg = g[base+i] | (p[base+i] & cg);
                    gg = g[base+i] | (p[base+i] & gg);
                    gp = gp & p[base+i];
                end
            end
            c = gg | (gp & c);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1      <= 1'b0;
            v2      <= 1'b0;
            v3      <= 1'b0;
            pp1     <= '{default: '0};
            approx1 <= 1'b0;
            approx2 <= 1'b0;
            approx3 <= 1'b0;
            tag1    <= '0;
            tag2    <= '0;
            tag3    <= '0;
            row_a2  <= '0;
            row_b2  <= '0;
            prod3   <= '0;
        end else begin
            if (load1) begin
                v1 <= in_valid;
                if (in_valid) begin
                    pp1     <= pp_d;
                    approx1 <= in_approx;
                    tag1    <= in_tag;
                end
            end
            if (load2) begin
                v2 <= v1;
                if (v1) begin
                    row_a2  <= row_a;
                    row_b2  <= row_b;
                    approx2 <= approx1;
                    tag2    <= tag1;
                end
            end
            if (load3) begin
                v3 <= v2;
                if (v2) begin
                    prod3   <= sum;
                    approx3 <= approx2;
                    tag3    <= tag2;
                end
            end
        end
    end

    assign out_valid  = v3;
    assign out_prod   = prod3;
    assign out_approx = approx3;
    assign out_tag    = tag3;
    assign overflow   = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_dadda_mul_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_dadda_mul_pipe : directed bench for dadda_mul_pipe (WIDTH=8)        |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_dadda_mul_pipe;

    typedef struct {
        logic [15:0] prod;
        logic [3:0]  tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_approx;
    logic [7:0]  in_a, in_b;
    logic [3:0]  in_tag, out_tag;
    logic        out_valid, out_ready, out_approx, overflow;
    logic [15:0] out_prod;

    int   nvec = 0;
    int   nerr = 0;
    exp_t exp_q [$];

    always #5 clk = ~clk;

    dadda_mul_pipe #(.WIDTH(8), .APPROX_COLS(4), .TAG_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_approx  (in_approx),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_prod   (out_prod),
        .out_approx (out_approx),
        .out_tag    (out_tag),
        .overflow   (overflow)
    );

    task automatic check(input string nm, input logic [63:0] obs, input logic [63:0] expv);
        nvec++;
        assert (obs === expv) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", nm, obs, expv);
        end
    endtask

    // Exact product minus the partial products masked off in approximate mode.
    function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b, input logic ap);
        logic [15:0] p;
        p = 16'(a) * 16'(b);
        if (ap) begin
            for (int i = 0; i < 8; i++)
                for (int j = 0; j < 8; j++)
                    if (i + j < 4 && a[i] && b[j]) p = p - (16'(1) << (i + j));
        end
        return p;
    endfunction

    task automatic single(input logic [7:0] a, input logic [7:0] b, input logic ap,
                          input logic [3:0] tg, input logic [15:0] expp, input string nm);
        int lat;
        @(negedge clk);
        in_a = a; in_b = b; in_approx = ap; in_tag = tg; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check({nm, "_in_ready"}, 64'(in_ready), 64'(1));
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        while (lat < 10) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
        end
        check({nm, "_latency"}, 64'(lat), 64'(3));
        check({nm, "_prod"}, 64'(out_prod), 64'(expp));
        check({nm, "_tag"}, 64'(out_tag), 64'(tg));
        check({nm, "_approx"}, 64'(out_approx), 64'(ap));
        check({nm, "_overflow"}, 64'(overflow), 64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   sent, got, nr;
        logic prev_stall;
        logic [15:0] prev_prod;
        logic [3:0]  prev_tag;
        exp_t e;

        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_approx = 1'b0; in_tag = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_prod", 64'(out_prod), 64'(0));
        check("rst_out_tag", 64'(out_tag), 64'(0));
        check("rst_out_approx", 64'(out_approx), 64'(0));
        check("rst_overflow", 64'(overflow), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(1));

        single(8'd15, 8'd15, 1'b0, 4'd3, 16'd225, "exact_15x15");
        single(8'd15, 8'd15, 1'b1, 4'd5, 16'd176, "approx_15x15");
        single(8'hFF, 8'h01, 1'b1, 4'd6, 16'h00F0, "approx_ffx01");
        single(8'd255, 8'd255, 1'b0, 4'd9, 16'd65025, "exact_255x255");
        single(8'd0, 8'd200, 1'b0, 4'd10, 16'd0, "zero_x200");

        // Back-to-back stream, out_ready held high.
        for (int n = 0; n < 22; n++) begin
            @(negedge clk);
            check("stream_valid", 64'(out_valid), 64'(n >= 3 && n < 19));
            if (n >= 3 && n < 19) begin
                check("stream_prod", 64'(out_prod), 64'((n - 3) * (n - 2)));
                check("stream_tag", 64'(out_tag), 64'(n - 3));
            end
            in_valid  = (n < 16);
            in_a      = 8'(n);
            in_b      = 8'(n + 1);
            in_tag    = 4'(n);
            in_approx = 1'b0;
        end

        // Fill the pipeline under backpressure.
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            out_ready = 1'b0; in_valid = 1'b1; in_approx = 1'b0;
            in_a = 8'(10 + n); in_b = 8'd20; in_tag = 4'(8 + n);
            #1;
            check("fill_in_ready", 64'(in_ready), 64'(n < 3));
            if (n >= 3) begin
                check("fill_out_valid", 64'(out_valid), 64'(1));
                check("fill_hold_prod", 64'(out_prod), 64'(200));
                check("fill_hold_tag", 64'(out_tag), 64'(8));
            end
        end

        // One-cycle reset with three beats in flight and a beat offered.
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", 64'(out_valid), 64'(0));
        check("midrst_in_ready", 64'(in_ready), 64'(1));
        check("midrst_out_prod", 64'(out_prod), 64'(0));
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            check("midrst_no_stale", 64'(out_valid), 64'(0));
        end

        // Random operands, out_ready high 30% of cycles, scoreboard in order.
        nr = 300; sent = 0; got = 0; prev_stall = 1'b0; prev_prod = '0; prev_tag = '0;
        for (int cyc = 0; cyc < 6000 && got < nr; cyc++) begin
            @(negedge clk);
            if (prev_stall) begin
                check("stall_valid", 64'(out_valid), 64'(1));
                check("stall_prod", 64'(out_prod), 64'(prev_prod));
                check("stall_tag", 64'(out_tag), 64'(prev_tag));
            end
            in_valid  = (sent < nr) && ($urandom_range(0, 3) != 0);
            in_a      = 8'($urandom);
            in_b      = 8'($urandom);
            in_approx = 1'($urandom);
            in_tag    = 4'($urandom);
            out_ready = ($urandom_range(0, 99) < 30);
            #1;
            if (in_valid && in_ready) begin
                e.prod = model(in_a, in_b, in_approx);
                e.tag  = in_tag;
                exp_q.push_back(e);
                sent++;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("rand_spurious", 64'(1), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("rand_prod", 64'(out_prod), 64'(e.prod));
                    check("rand_tag", 64'(out_tag), 64'(e.tag));
                end
                got++;
            end
            prev_stall = out_valid && !out_ready;
            prev_prod  = out_prod;
            prev_tag   = out_tag;
        end
        check("rand_all_received", 64'(got), 64'(nr));
        in_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire
